load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Initiator side of the RV32 data-memory port. Accepts one load/store at a time from the
//  pipeline MEM stage, drives a word-addressed memory with byte enables, waits for the memory
//  response, then returns aligned and extended load data. Flags misaligned accesses, illegal
//  width codes and memory timeouts as errors; no memory access is issued for a flagged request.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max cycles spent in REQ+WAIT before an error response; 0 disables
// PORTS
//  clk            in   1   clock, rising edge; only clock
//  rst            in   1   reset, synchronous, active-high
//  req_valid_i    in   1   pipeline request valid
//  req_ready_o    out  1   unit can accept (high only in IDLE)
//  req_we_i       in   1   1=store, 0=load
//  req_addr_i     in   32  byte address
//  req_wdata_i    in   32  store data (LSBs used for B/H)
//  req_type_i     in   3   funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  resp_valid_o   out  1   one-cycle response pulse
//  resp_rdata_o   out  32  load result, extended; 0 for stores and errors
//  resp_err_o     out  1   misaligned / illegal type / timeout
//  mem_req_o      out  1   memory request, held until granted
//  mem_gnt_i      in   1   memory accepts request this cycle
//  mem_we_o       out  1   memory write
//  mem_addr_o     out  32  word address {req_addr[31:2],2'b00}
//  mem_be_o       out  4   byte enables
//  mem_wdata_o    out  32  lane-replicated store data
//  mem_rvalid_i   in   1   memory response (loads and store acks)
//  mem_rdata_i    in   32  raw memory word
// BEHAVIOUR
//  - Reset: state=IDLE; req_ready_o=1; resp_valid_o, resp_err_o, mem_req_o, mem_we_o = 0;
//    resp_rdata_o, mem_addr_o, mem_be_o, mem_wdata_o = 0; timeout counter = 0.
//  - All outputs registered except req_ready_o = (state==IDLE).
//  - FSM IDLE->REQ->WAIT->RESP->IDLE; IDLE->RESP directly on a check error.
//  - IDLE: on req_valid_i, capture we/addr/wdata/type and check:
//      type in {011,110,111} -> illegal; H/HU with addr[0]=1 or W with addr[1:0]!=0 -> misaligned.
//      Error: next cycle RESP with resp_err_o=1, rdata=0; mem_req_o never asserted.
//      Otherwise: next cycle REQ with mem_req_o=1 and mem_addr/we/be/wdata valid.
//  - Lanes, o=addr[1:0]: B/BU be=4'b0001<<o, wdata={4{wd[7:0]}}; H/HU be=4'b0011<<o,
//    wdata={2{wd[15:0]}}; W be=4'b1111, wdata=wd. be is driven for loads too.
//  - REQ: mem_* held stable until mem_gnt_i=1; on that edge mem_req_o drops, go WAIT.
//  - WAIT: on mem_rvalid_i go RESP. Load: s=mem_rdata_i>>(8*o); B sign-ext s[7:0],
//    BU zero-ext s[7:0], H sign-ext s[15:0], HU zero-ext s[15:0], W s. Store: rdata=0.
//  - mem_rvalid_i outside WAIT, incl. same cycle as gnt, is ignored.
//  - RESP: resp_valid_o=1 for exactly one cycle, then IDLE; resp_err_o/rdata valid only there.
//  - Latency: accept at edge N, gnt in first REQ cycle, rvalid in first WAIT cycle ->
//    resp_valid_o high in cycle N+3. Check-error response in cycle N+1.
//  - Timeout: counter clears on accept, increments each cycle in REQ/WAIT. If it reaches
//    TIMEOUT_CYCLES: go RESP with err=1, rdata=0; mem_req_o drops; late rvalid is ignored.
//  - A new request is accepted only in IDLE, so back-to-back requests are 1 cycle apart
//    after RESP. req_* inputs outside IDLE are don't-care.
//  - rst mid-operation: state returns to IDLE and outputs take reset values on that edge;
//    no response is produced for the aborted access.
// TESTING
//  - SW 0xDEADBEEF @0x100, gnt/rvalid immediate -> be=1111, addr=0x100, resp at N+3, err=0
//  - SB 0x000000A5 @0x103 -> be=1000, wdata=0xA5A5A5A5, mem_addr_o=0x100
//  - LB/LBU @0x102, mem_rdata_i=0x12F03456 -> LB 0xFFFFFFF0, LBU 0x000000F0
//  - LH @0x101 -> err=1 at N+1, mem_req_o never high; type 011 -> same
//  - gnt delayed 5 cycles -> mem_* stable throughout; TIMEOUT_CYCLES=4 with no rvalid -> err=1
//  - rst asserted in WAIT -> IDLE next edge, no resp_valid_o, then a new LW completes normally

Source files
------------

// File: rtl/load_store_unit_if.sv
// Word-addressed data-memory bus between the load/store unit (master) and memory (slave).
// Member names carry the direction suffix as seen from the load/store unit.
interface load_store_unit_if;
    logic        mem_req_o;
    logic        mem_gnt_i;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    modport master (
        output mem_req_o,
        output mem_we_o,
        output mem_addr_o,
        output mem_be_o,
        output mem_wdata_o,
        input  mem_gnt_i,
        input  mem_rvalid_i,
        input  mem_rdata_i
    );

    modport slave (
        input  mem_req_o,
        input  mem_we_o,
        input  mem_addr_o,
        input  mem_be_o,
        input  mem_wdata_o,
        output mem_gnt_i,
        output mem_rvalid_i,
        output mem_rdata_i
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32 data-memory initiator: one load/store in flight, byte-lane steering,
// load extension, and error responses for misalignment, illegal width and timeout.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [2:0]  req_type_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    load_store_unit_if.master mem
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_we;
    logic [2:0]  r_type;
    logic [1:0]  r_off;
    logic [31:0] r_cnt;

    logic        r_mem_req;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [3:0]  r_mem_be;
    logic [31:0] r_mem_wdata;
    logic        r_resp_valid;
    logic        r_resp_err;
    logic [31:0] r_resp_rdata;

    logic        w_we_next;
    logic [2:0]  w_type_next;
    logic [1:0]  w_off_next;
    logic [31:0] w_cnt_next;
    logic        w_mem_req_next;
    logic        w_mem_we_next;
    logic [31:0] w_mem_addr_next;
    logic [3:0]  w_mem_be_next;
    logic [31:0] w_mem_wdata_next;
    logic        w_resp_valid_next;
    logic        w_resp_err_next;
    logic [31:0] w_resp_rdata_next;

    logic        w_illegal;
    logic        w_misaligned;
    logic        w_chk_err;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [31:0] w_shift;
    logic [31:0] w_load_data;
    logic [31:0] w_cnt_inc;
    logic        w_timeout;

    // Request checks and lane steering are evaluated on the raw inputs so the
    // registered memory outputs are valid in the very first REQ cycle.
    always_comb begin
        w_illegal    = (req_type_i == 3'b011) || (req_type_i == 3'b110) || (req_type_i == 3'b111);
        w_misaligned = ((req_type_i[1:0] == 2'b01) && req_addr_i[0]) ||
                       ((req_type_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
        w_chk_err    = w_illegal || w_misaligned;
    end

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = req_wdata_i;
        case (req_type_i[1:0])
            2'b00: begin
                w_be    = 4'b0001 << req_addr_i[1:0];
                w_wdata = {4{req_wdata_i[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << req_addr_i[1:0];
                w_wdata = {2{req_wdata_i[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = req_wdata_i;
            end
        endcase
    end

    always_comb begin
        w_shift     = mem.mem_rdata_i >> {r_off, 3'b000};
        w_load_data = w_shift;
        case (r_type)
            3'b000:  w_load_data = {{24{w_shift[7]}}, w_shift[7:0]};
            3'b100:  w_load_data = {24'd0, w_shift[7:0]};
            3'b001:  w_load_data = {{16{w_shift[15]}}, w_shift[15:0]};
            3'b101:  w_load_data = {16'd0, w_shift[15:0]};
            default: w_load_data = w_shift;
        endcase
    end

    // Counter value after this cycle; the limit is hit when REQ+WAIT has lasted TIMEOUT_CYCLES.
    assign w_cnt_inc = r_cnt + 32'd1;
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (w_cnt_inc == TIMEOUT_CYCLES);

    always_comb begin
        w_state_next      = r_state;
        w_we_next         = r_we;
        w_type_next       = r_type;
        w_off_next        = r_off;
        w_cnt_next        = r_cnt;
        w_mem_req_next    = r_mem_req;
        w_mem_we_next     = r_mem_we;
        w_mem_addr_next   = r_mem_addr;
        w_mem_be_next     = r_mem_be;
        w_mem_wdata_next  = r_mem_wdata;
        w_resp_valid_next = 1'b0;
        w_resp_err_next   = 1'b0;
        w_resp_rdata_next = 32'd0;

        case (r_state)
            S_IDLE: begin
                if (req_valid_i) begin
                    w_we_next   = req_we_i;
                    w_type_next = req_type_i;
                    w_off_next  = req_addr_i[1:0];
                    w_cnt_next  = 32'd0;
                    if (w_chk_err) begin
                        w_state_next      = S_RESP;
                        w_resp_valid_next = 1'b1;
                        w_resp_err_next   = 1'b1;
                    end else begin
                        w_state_next     = S_REQ;
                        w_mem_req_next   = 1'b1;
                        w_mem_we_next    = req_we_i;
                        w_mem_addr_next  = {req_addr_i[31:2], 2'b00};
                        w_mem_be_next    = w_be;
                        w_mem_wdata_next = w_wdata;
                    end
                end
            end
            S_REQ: begin
                w_cnt_next = w_cnt_inc;
                if (mem.mem_gnt_i) begin
                    w_mem_req_next = 1'b0;
                    w_state_next   = S_WAIT;
                end else if (w_timeout) begin
                    w_mem_req_next    = 1'b0;
                    w_state_next      = S_RESP;
                    w_resp_valid_next = 1'b1;
                    w_resp_err_next   = 1'b1;
                end
            end
            S_WAIT: begin
                w_cnt_next = w_cnt_inc;
                if (mem.mem_rvalid_i) begin
                    w_state_next      = S_RESP;
                    w_resp_valid_next = 1'b1;
                    w_resp_rdata_next = r_we ? 32'd0 : w_load_data;
                end else if (w_timeout) begin
                    w_state_next      = S_RESP;
                    w_resp_valid_next = 1'b1;
                    w_resp_err_next   = 1'b1;
                end
            end
            S_RESP: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_we         <= 1'b0;
            r_type       <= 3'd0;
            r_off        <= 2'd0;
            r_cnt        <= 32'd0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= 32'd0;
            r_mem_be     <= 4'd0;
            r_mem_wdata  <= 32'd0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= 32'd0;
        end else begin
            r_state      <= w_state_next;
            r_we         <= w_we_next;
            r_type       <= w_type_next;
            r_off        <= w_off_next;
            r_cnt        <= w_cnt_next;
            r_mem_req    <= w_mem_req_next;
            r_mem_we     <= w_mem_we_next;
            r_mem_addr   <= w_mem_addr_next;
            r_mem_be     <= w_mem_be_next;
            r_mem_wdata  <= w_mem_wdata_next;
            r_resp_valid <= w_resp_valid_next;
            r_resp_err   <= w_resp_err_next;
            r_resp_rdata <= w_resp_rdata_next;
        end
    end

    assign req_ready_o     = (r_state == S_IDLE);
    assign resp_valid_o    = r_resp_valid;
    assign resp_err_o      = r_resp_err;
    assign resp_rdata_o    = r_resp_rdata;
    assign mem.mem_req_o   = r_mem_req;
    assign mem.mem_we_o    = r_mem_we;
    assign mem.mem_addr_o  = r_mem_addr;
    assign mem.mem_be_o    = r_mem_be;
    assign mem.mem_wdata_o = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: responses are checked against a scoreboard
// queue filled as requests are accepted; a second instance exercises the timeout.
module tb_load_store_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    // Main DUT (default timeout)
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [2:0]  req_type = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    load_store_unit_if bus ();

    load_store_unit dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_we_i     (req_we),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .req_type_i   (req_type),
        .resp_valid_o (resp_valid),
        .resp_rdata_o (resp_rdata),
        .resp_err_o   (resp_err),
        .mem          (bus.master)
    );

    // Second DUT with a short timeout
    logic        t_req_valid = 1'b0;
    logic        t_req_ready;
    logic        t_resp_valid;
    logic [31:0] t_resp_rdata;
    logic        t_resp_err;
    load_store_unit_if bus_t ();

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut_t (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (t_req_valid),
        .req_ready_o  (t_req_ready),
        .req_we_i     (1'b0),
        .req_addr_i   (32'h0000_0010),
        .req_wdata_i  (32'd0),
        .req_type_i   (3'b010),
        .resp_valid_o (t_resp_valid),
        .resp_rdata_o (t_resp_rdata),
        .resp_err_o   (t_resp_err),
        .mem          (bus_t.master)
    );

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
        int          acc;
        string       tag;
    } exp_t;

    exp_t exp_q[$];
    logic seen_req = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Response monitor: every resp_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (bus.mem_req_o) seen_req = 1'b1;
        if (resp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_resp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check({e.tag, "_err"}, {31'd0, resp_err}, {31'd0, e.err});
                check({e.tag, "_rdata"}, resp_rdata, e.rdata);
                check({e.tag, "_lat"}, cyc - e.acc + 1, e.lat);
                $display("resp %s err=%0b rdata=%h lat=%0d", e.tag, resp_err, resp_rdata, cyc - e.acc + 1);
            end
        end
    end

    // Called #1 after a posedge; returns #1 after the accept edge.
    task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [2:0] ty,
                          input logic exp_err, input logic [31:0] exp_rd, input int exp_lat);
        exp_t e;
        for (int i = 0; i < 20 && req_ready !== 1'b1; i++) @(posedge clk) #1;
        check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_type  = ty;
        @(posedge clk) #1;
        req_valid = 1'b0;
        e.err = exp_err; e.rdata = exp_rd; e.lat = exp_lat; e.acc = cyc; e.tag = tag;
        exp_q.push_back(e);
    endtask

    // Grants after gnt_delay REQ cycles (with a spurious rvalid during those), then returns data.
    task automatic mem_cycle(input string tag, input int gnt_delay, input logic [31:0] rd,
                             input logic exp_we, input logic [31:0] exp_addr,
                             input logic [3:0] exp_be, input logic [31:0] exp_wd);
        for (int i = 0; i <= gnt_delay; i++) begin
            check({tag, "_req"},   {31'd0, bus.mem_req_o}, 32'd1);
            check({tag, "_we"},    {31'd0, bus.mem_we_o}, {31'd0, exp_we});
            check({tag, "_addr"},  bus.mem_addr_o, exp_addr);
            check({tag, "_be"},    {28'd0, bus.mem_be_o}, {28'd0, exp_be});
            check({tag, "_wdata"}, bus.mem_wdata_o, exp_wd);
            if (i < gnt_delay) begin
                bus.mem_rvalid_i = 1'b1;
                bus.mem_rdata_i  = 32'hBAD0_BAD0;
                @(posedge clk) #1;
                bus.mem_rvalid_i = 1'b0;
            end
        end
        bus.mem_gnt_i = 1'b1;
        @(posedge clk) #1;
        bus.mem_gnt_i    = 1'b0;
        check({tag, "_req_drop"}, {31'd0, bus.mem_req_o}, 32'd0);
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = rd;
        @(posedge clk) #1;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = 32'd0;
    endtask

    initial begin
        int t_acc;
        int pulses;
        bus.mem_gnt_i = 1'b0;    bus.mem_rvalid_i = 1'b0;   bus.mem_rdata_i = '0;
        bus_t.mem_gnt_i = 1'b0;  bus_t.mem_rvalid_i = 1'b0; bus_t.mem_rdata_i = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready",   {31'd0, req_ready}, 32'd1);
        check("rst_rvalid",  {31'd0, resp_valid}, 32'd0);
        check("rst_err",     {31'd0, resp_err}, 32'd0);
        check("rst_rdata",   resp_rdata, 32'd0);
        check("rst_memreq",  {31'd0, bus.mem_req_o}, 32'd0);
        check("rst_memwe",   {31'd0, bus.mem_we_o}, 32'd0);
        check("rst_addr",    bus.mem_addr_o, 32'd0);
        check("rst_be",      {28'd0, bus.mem_be_o}, 32'd0);
        check("rst_wdata",   bus.mem_wdata_o, 32'd0);
        rst = 1'b0;
        @(posedge clk) #1;

        do_req("sw", 1'b1, 32'h100, 32'hDEADBEEF, 3'b010, 1'b0, 32'd0, 3);
        check("sw_busy", {31'd0, req_ready}, 32'd0);
        mem_cycle("sw", 0, 32'h1234_5678, 1'b1, 32'h100, 4'b1111, 32'hDEADBEEF);

        do_req("sb", 1'b1, 32'h103, 32'h0000_00A5, 3'b000, 1'b0, 32'd0, 3);
        mem_cycle("sb", 0, 32'h0, 1'b1, 32'h100, 4'b1000, 32'hA5A5A5A5);

        do_req("lb", 1'b0, 32'h102, 32'h0, 3'b000, 1'b0, 32'hFFFF_FFF0, 3);
        mem_cycle("lb", 0, 32'h12F0_3456, 1'b0, 32'h100, 4'b0100, 32'h0);

        do_req("lbu", 1'b0, 32'h102, 32'h0, 3'b100, 1'b0, 32'h0000_00F0, 3);
        mem_cycle("lbu", 0, 32'h12F0_3456, 1'b0, 32'h100, 4'b0100, 32'h0);

        do_req("lh_hi", 1'b0, 32'h102, 32'h0, 3'b001, 1'b0, 32'h0000_12F0, 3);
        mem_cycle("lh_hi", 0, 32'h12F0_3456, 1'b0, 32'h100, 4'b1100, 32'h0);

        do_req("lh_lo", 1'b0, 32'h200, 32'h0, 3'b001, 1'b0, 32'hFFFF_8001, 3);
        mem_cycle("lh_lo", 0, 32'h0000_8001, 1'b0, 32'h200, 4'b0011, 32'h0);

        do_req("lhu", 1'b0, 32'h200, 32'h0, 3'b101, 1'b0, 32'h0000_8001, 3);
        mem_cycle("lhu", 0, 32'h0000_8001, 1'b0, 32'h200, 4'b0011, 32'h0);

        do_req("sh", 1'b1, 32'h202, 32'hFFFF_BEEF, 3'b001, 1'b0, 32'd0, 3);
        mem_cycle("sh", 0, 32'h0, 1'b1, 32'h200, 4'b1100, 32'hBEEF_BEEF);

        // Check errors: immediate error response, no memory request ever.
        seen_req = 1'b0;
        do_req("lh_mis", 1'b0, 32'h101, 32'h0, 3'b001, 1'b1, 32'd0, 1);
        repeat (3) @(posedge clk) #1;
        check("lh_mis_noreq", {31'd0, seen_req}, 32'd0);

        seen_req = 1'b0;
        do_req("ty011", 1'b0, 32'h100, 32'h0, 3'b011, 1'b1, 32'd0, 1);
        repeat (3) @(posedge clk) #1;
        check("ty011_noreq", {31'd0, seen_req}, 32'd0);

        seen_req = 1'b0;
        do_req("sw_mis", 1'b1, 32'h102, 32'h1, 3'b010, 1'b1, 32'd0, 1);
        repeat (3) @(posedge clk) #1;
        check("sw_mis_noreq", {31'd0, seen_req}, 32'd0);

        // Delayed grant with spurious rvalid in REQ: outputs stay put, rvalid ignored.
        do_req("lw_dly", 1'b0, 32'h204, 32'h0, 3'b010, 1'b0, 32'h0BAD_F00D, 8);
        mem_cycle("lw_dly", 5, 32'h0BAD_F00D, 1'b0, 32'h204, 4'b1111, 32'h0);

        // Reset while waiting for read data: the access is dropped silently.
        do_req("lw_abort", 1'b0, 32'h300, 32'h0, 3'b010, 1'b0, 32'd0, 3);
        void'(exp_q.pop_back());
        bus.mem_gnt_i = 1'b1;
        @(posedge clk) #1;
        bus.mem_gnt_i = 1'b0;
        rst = 1'b1;
        @(posedge clk) #1;
        rst = 1'b0;
        check("abort_ready",  {31'd0, req_ready}, 32'd1);
        check("abort_memreq", {31'd0, bus.mem_req_o}, 32'd0);
        bus.mem_rvalid_i = 1'b1;
        bus.mem_rdata_i  = 32'h7777_7777;
        @(posedge clk) #1;
        bus.mem_rvalid_i = 1'b0;
        repeat (3) @(posedge clk) #1;

        do_req("lw_after", 1'b0, 32'h304, 32'h0, 3'b010, 1'b0, 32'h55AA_55AA, 3);
        mem_cycle("lw_after", 0, 32'h55AA_55AA, 1'b0, 32'h304, 4'b1111, 32'h0);
        repeat (3) @(posedge clk) #1;
        check("sb_empty", exp_q.size(), 32'd0);

        // Timeout instance: never granted, error after 4 cycles in REQ.
        t_req_valid = 1'b1;
        @(posedge clk) #1;
        t_req_valid = 1'b0;
        t_acc = cyc;
        check("tmo_memreq", {31'd0, bus_t.mem_req_o}, 32'd1);
        for (int i = 0; i < 20 && t_resp_valid !== 1'b1; i++) @(negedge clk);
        check("tmo_resp",   {31'd0, t_resp_valid}, 32'd1);
        check("tmo_err",    {31'd0, t_resp_err}, 32'd1);
        check("tmo_rdata",  t_resp_rdata, 32'd0);
        check("tmo_lat",    cyc - t_acc + 1, 32'd5);
        check("tmo_memoff", {31'd0, bus_t.mem_req_o}, 32'd0);
        $display("resp tmo err=%0b rdata=%h lat=%0d", t_resp_err, t_resp_rdata, cyc - t_acc + 1);
        bus_t.mem_rvalid_i = 1'b1;
        bus_t.mem_rdata_i  = 32'h1111_1111;
        pulses = 0;
        @(posedge clk) #1;
        bus_t.mem_rvalid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (t_resp_valid === 1'b1) pulses++;
        end
        check("tmo_late_ign", pulses, 32'd0);
        check("tmo_ready",    {31'd0, t_req_ready}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
